// File: rtl/tlc_mon_pkg.sv
// Shared types for the traffic-light lamp monitor: fault codes, lamp encoding
// and small lamp-vector helpers used by the filter and the checkers.
package tlc_mon_pkg;

  typedef enum logic [2:0] {
    NONE        = 3'd0,
    CONFLICT    = 3'd1,
    ENCODING    = 3'd2,
    SEQUENCE    = 3'd3,
    SHORT_AMBER = 3'd4,
    WATCHDOG    = 3'd5
  } fault_code_e;

  localparam int unsigned LAMP_G = 2;
  localparam int unsigned LAMP_O = 1;
  localparam int unsigned LAMP_R = 0;

  typedef logic [2:0] lamp_t;

  localparam lamp_t LAMP_RED = 3'(1 << LAMP_R);
  localparam lamp_t LAMP_AMB = 3'(1 << LAMP_O);
  localparam lamp_t LAMP_GRN = 3'(1 << LAMP_G);

  function automatic logic is_lit(input lamp_t l);
    return l[LAMP_G] | l[LAMP_O];
  endfunction

  // Only G->O, O->R and R->G are legal; steps involving a non-one-hot value
  // are left to the encoding check.
  function automatic logic bad_step(input lamp_t from, input lamp_t to);
    logic legal;
    legal = ((from == LAMP_GRN) && (to == LAMP_AMB)) ||
            ((from == LAMP_AMB) && (to == LAMP_RED)) ||
            ((from == LAMP_RED) && (to == LAMP_GRN));
    return $onehot(from) && $onehot(to) && (from != to) && !legal;
  endfunction

endpackage

// File: rtl/tlc_lamp_filter.sv
// Glitch filter for the six lamp read-back lines: a vector is accepted once it
// has been sampled FILT_CYC times in a row (FILT_CYC=0 passes every sample).
module tlc_lamp_filter
  import tlc_mon_pkg::*;
#(
  parameter int unsigned FILT_CYC = 2
)(
  input  logic       clk,
  input  logic       res_n,
  input  logic [5:0] raw,
  output logic [5:0] acc,
  output logic       acc_chg
);

  localparam logic [5:0] ALL_RED = {LAMP_RED, LAMP_RED};

  generate
    if (FILT_CYC == 0) begin : g_bypass
      always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
          acc     <= ALL_RED;
          acc_chg <= 1'b0;
        end else begin
          acc_chg <= (raw != acc);
          acc     <= raw;
        end
      end
    end else begin : g_filt
      localparam int unsigned CW = $clog2(FILT_CYC + 1);
      localparam logic [CW-1:0] STAB_MAX = CW'(FILT_CYC - 1);

      logic [5:0]    samp;
      logic [CW-1:0] stab;
      logic          take;

      // stab counts repeats after the first sample, so STAB_MAX repeats means
      // FILT_CYC identical samples are now sitting in samp.
      assign take = (stab >= STAB_MAX) && (samp != acc);

      always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
          samp    <= ALL_RED;
          stab    <= '0;
          acc     <= ALL_RED;
          acc_chg <= 1'b0;
        end else begin
          samp <= raw;
          if (raw != samp)
            stab <= '0;
          else if (stab != STAB_MAX)
            stab <= stab + 1'b1;
          acc_chg <= take;
          if (take)
            acc <= samp;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/tlc_lamp_monitor.sv
// Lamp conflict/malfunction monitor: checks filtered lamp read-back, latches the
// first fault and drives the flash blink. TLC_MON_WATCHDOG_EN adds a stall watchdog.
module tlc_lamp_monitor
  import tlc_mon_pkg::*;
#(
  parameter int unsigned FILT_CYC  = 2,
  parameter int unsigned MIN_AMBER = 4,
`ifdef TLC_MON_WATCHDOG_EN
  parameter int unsigned MAX_STALL = 1000,
`endif
  parameter int unsigned BLINK_CYC = 50
)(
  input  logic       clk,
  input  logic       res_n,
  input  logic       ga,
  input  logic       oa,
  input  logic       ra,
  input  logic       gb,
  input  logic       ob,
  input  logic       rb,
  input  logic       clr_fault,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash
);

  localparam int unsigned AW = $clog2(MIN_AMBER + 1);
  localparam logic [AW-1:0] AMB_MAX = AW'(MIN_AMBER);
  localparam int unsigned FW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam logic [FW-1:0] BLINK_LAST = FW'(BLINK_CYC - 1);

  logic [5:0]    acc;
  logic          acc_chg;
  lamp_t         acc_a, acc_b, ref_a, ref_b;
  logic [AW-1:0] amb_a, amb_b;
  logic [FW-1:0] blink_cnt;
  logic          conflict, enc_bad, seq_bad, short_amb, det, clr_ok;
  fault_code_e   chk_code;

  tlc_lamp_filter #(.FILT_CYC(FILT_CYC)) u_filter (
    .clk     (clk),
    .res_n   (res_n),
    .raw     ({ga, oa, ra, gb, ob, rb}),
    .acc     (acc),
    .acc_chg (acc_chg)
  );

  assign acc_a = acc[5:3];
  assign acc_b = acc[2:0];

  assign conflict  = is_lit(acc_a) && is_lit(acc_b);
  assign enc_bad   = !$onehot(acc_a) || !$onehot(acc_b);
  assign seq_bad   = bad_step(ref_a, acc_a) || bad_step(ref_b, acc_b);
  // Amber counters still hold the pre-change count in the cycle acc_chg is high.
  assign short_amb = ((ref_a == LAMP_AMB) && (acc_a == LAMP_RED) && (amb_a < AMB_MAX)) ||
                     ((ref_b == LAMP_AMB) && (acc_b == LAMP_RED) && (amb_b < AMB_MAX));

`ifdef TLC_MON_WATCHDOG_EN
  localparam int unsigned SW = $clog2(MAX_STALL + 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(MAX_STALL);
  logic [SW-1:0] stall_cnt;
`endif

  always_comb begin
    chk_code = NONE;
    if (acc_chg) begin
      if (conflict)       chk_code = CONFLICT;
      else if (enc_bad)   chk_code = ENCODING;
      else if (seq_bad)   chk_code = SEQUENCE;
      else if (short_amb) chk_code = SHORT_AMBER;
    end
`ifdef TLC_MON_WATCHDOG_EN
    if ((chk_code == NONE) && !acc_chg && (stall_cnt == STALL_MAX))
      chk_code = WATCHDOG;
`endif
  end

  assign det    = !fault && (chk_code != NONE);
  assign clr_ok = fault && clr_fault && !conflict && !enc_bad;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      fault      <= 1'b0;
      fault_code <= NONE;
      flash      <= 1'b0;
      blink_cnt  <= '0;
      ref_a      <= LAMP_RED;
      ref_b      <= LAMP_RED;
      amb_a      <= '0;
      amb_b      <= '0;
    end else begin
      if (det) begin
        fault      <= 1'b1;
        fault_code <= chk_code;
      end else if (clr_ok) begin
        fault      <= 1'b0;
        fault_code <= NONE;
      end

      if (!fault || clr_ok) begin
        blink_cnt <= '0;
        flash     <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        flash     <= ~flash;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      if (acc_chg || clr_ok) begin
        ref_a <= acc_a;
        ref_b <= acc_b;
      end

      if (clr_ok || (acc_a != LAMP_AMB)) amb_a <= '0;
      else if (amb_a != AMB_MAX)          amb_a <= amb_a + 1'b1;

      if (clr_ok || (acc_b != LAMP_AMB)) amb_b <= '0;
      else if (amb_b != AMB_MAX)          amb_b <= amb_b + 1'b1;
    end
  end

`ifdef TLC_MON_WATCHDOG_EN
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n)
      stall_cnt <= '0;
    else if (acc_chg || clr_ok)
      stall_cnt <= '0;
    else if (stall_cnt != STALL_MAX)
      stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_tlc_lamp_monitor.sv
// Directed bench for tlc_lamp_monitor: legal cycle table, fault case table and
// hand-written sequences for latency, flash, clear, reset and watchdog.
module tb_tlc_lamp_monitor;

  logic       clk = 1'b0;
  logic       res_n;
  logic       ga, oa, ra, gb, ob, rb;
  logic       clr_fault;
  logic       fault;
  logic [2:0] fault_code;
  logic       flash;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tlc_lamp_monitor dut (
    .clk        (clk),
    .res_n      (res_n),
    .ga         (ga),
    .oa         (oa),
    .ra         (ra),
    .gb         (gb),
    .ob         (ob),
    .rb         (rb),
    .clr_fault  (clr_fault),
    .fault      (fault),
    .fault_code (fault_code),
    .flash      (flash)
  );

  typedef struct {
    logic [5:0] lamps;
    int         hold;
    int         exp_fault;
    int         exp_code;
  } step_t;

  typedef struct {
    logic [5:0] v1;
    int         n1;
    logic [5:0] v2;
    int         n2;
    logic [5:0] v3;
    int         exp_code;
  } fcase_t;

  step_t  legal_tab [12];
  fcase_t fault_tab [13];

  task automatic set_lamps(input logic [5:0] v);
    {ga, oa, ra, gb, ob, rb} = v;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input int f, input int c, input int fl);
    check({name, ".fault"}, int'(fault), f);
    check({name, ".code"}, int'(fault_code), c);
    check({name, ".flash"}, int'(flash), fl);
  endtask

  task automatic do_reset();
    res_n     = 1'b0;
    clr_fault = 1'b0;
    set_lamps(6'b001_001);
    tick(2);
    res_n = 1'b1;
    tick(8);
  endtask

  task automatic pulse_clr();
    clr_fault = 1'b1;
    tick(1);
    clr_fault = 1'b0;
  endtask

  initial begin
    legal_tab[0]  = '{6'b001_001,  5, 0, 0};
    legal_tab[1]  = '{6'b100_001, 20, 0, 0};
    legal_tab[2]  = '{6'b010_001,  5, 0, 0};
    legal_tab[3]  = '{6'b001_001, 10, 0, 0};
    legal_tab[4]  = '{6'b100_001, 10, 0, 0};
    legal_tab[5]  = '{6'b110_001,  1, 0, 0};
    legal_tab[6]  = '{6'b100_001, 10, 0, 0};
    legal_tab[7]  = '{6'b010_001,  4, 0, 0};
    legal_tab[8]  = '{6'b001_001, 10, 0, 0};
    legal_tab[9]  = '{6'b001_100, 10, 0, 0};
    legal_tab[10] = '{6'b001_010,  6, 0, 0};
    legal_tab[11] = '{6'b001_001, 10, 0, 0};

    fault_tab[0]  = '{6'b100_001, 10, 6'b100_001, 1, 6'b100_100, 1};
    fault_tab[1]  = '{6'b001_001,  5, 6'b001_001, 1, 6'b100_100, 1};
    fault_tab[2]  = '{6'b001_001,  5, 6'b001_001, 1, 6'b000_001, 2};
    fault_tab[3]  = '{6'b001_001,  5, 6'b001_001, 1, 6'b101_101, 1};
    fault_tab[4]  = '{6'b001_001,  5, 6'b001_001, 1, 6'b110_001, 2};
    fault_tab[5]  = '{6'b100_001, 10, 6'b100_001, 1, 6'b001_001, 3};
    fault_tab[6]  = '{6'b001_001,  5, 6'b001_001, 1, 6'b010_001, 3};
    fault_tab[7]  = '{6'b001_100, 10, 6'b001_100, 1, 6'b001_001, 3};
    fault_tab[8]  = '{6'b100_001, 10, 6'b010_001, 5, 6'b100_001, 3};
    fault_tab[9]  = '{6'b100_001, 10, 6'b010_001, 2, 6'b001_001, 4};
    fault_tab[10] = '{6'b100_001, 10, 6'b010_001, 3, 6'b001_001, 4};
    fault_tab[11] = '{6'b100_001, 10, 6'b010_001, 1, 6'b001_001, 3};
    fault_tab[12] = '{6'b001_100, 10, 6'b001_010, 2, 6'b001_001, 4};

    do_reset();
    check_out("reset", 0, 0, 0);

    // Legal A and B cycles, including the exact MIN_AMBER amber and a 1-cycle glitch.
    for (int i = 0; i < 12; i++) begin
      set_lamps(legal_tab[i].lamps);
      tick(legal_tab[i].hold);
      check_out($sformatf("legal[%0d]", i), legal_tab[i].exp_fault, legal_tab[i].exp_code, 0);
    end

    for (int i = 0; i < 13; i++) begin
      do_reset();
      set_lamps(fault_tab[i].v1);
      tick(fault_tab[i].n1);
      set_lamps(fault_tab[i].v2);
      tick(fault_tab[i].n2);
      check($sformatf("fcase[%0d].pre", i), int'(fault), 0);
      set_lamps(fault_tab[i].v3);
      tick(10);
      check($sformatf("fcase[%0d].fault", i), int'(fault), 1);
      check($sformatf("fcase[%0d].code", i), int'(fault_code), fault_tab[i].exp_code);
    end

    // Detection latency, flash timing, then async reset while flash is high.
    do_reset();
    set_lamps(6'b100_100);
    tick(3);
    check("lat.edge3", int'(fault), 0);
    tick(1);
    check("lat.edge4", int'(fault), 1);
    check("lat.code", int'(fault_code), 1);
    tick(49);
    check("flash.f49", int'(flash), 0);
    tick(1);
    check("flash.f50", int'(flash), 1);
    tick(49);
    check("flash.f99", int'(flash), 1);
    tick(1);
    check("flash.f100", int'(flash), 0);
    tick(60);
    check("flash.f160", int'(flash), 1);
    #2 res_n = 1'b0;
    #1 check_out("mid_reset", 0, 0, 0);

    // Clear: refused on an illegal vector, accepted on all-red, checks resume.
    do_reset();
    set_lamps(6'b100_001);
    tick(10);
    set_lamps(6'b001_001);
    tick(10);
    check_out("clr.seq", 1, 3, 0);
    set_lamps(6'b100_100);
    tick(10);
    pulse_clr();
    check("clr.illegal.fault", int'(fault), 1);
    check("clr.illegal.code", int'(fault_code), 3);
    set_lamps(6'b001_001);
    tick(10);
    pulse_clr();
    check_out("clr.ok", 0, 0, 0);
    set_lamps(6'b100_001);
    tick(10);
    check_out("clr.resume", 0, 0, 0);
    set_lamps(6'b001_001);
    tick(10);
    check_out("clr.resume_seq", 1, 3, 0);

    // Watchdog: 998 quiet cycles after reset are fine; 1018 trips it when built.
    do_reset();
    tick(990);
    check("wd.early", int'(fault), 0);
    tick(20);
`ifdef TLC_MON_WATCHDOG_EN
    check("wd.fault", int'(fault), 1);
    check("wd.code", int'(fault_code), 5);
`else
    check("wd.fault", int'(fault), 0);
    check("wd.code", int'(fault_code), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
